dvi_frame_reader: RTL and testbench
===================================

DVI_FRAME_READER -- requirements
Module: dvi_frame_reader

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync width and back porch in clocks.
REQ-003 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch, sync width and back porch in lines.
REQ-005 Parameter RD_LATENCY, default 2, dvi_clk cycles from read strobe to valid pixel data on iData.
REQ-006 dvi_clk  in  1  the only clock; all logic is on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  level; high requests video output.
REQ-009 iData  in  32  pixel word from the frame buffer read port; R=[23:16], G=[15:8], B=[7:0], [31:24] ignored.
REQ-010 iEmpty  in  1  frame buffer read FIFO empty while a read is requested.
REQ-011 oRead  out  1  read strobe to the frame buffer, one pixel per cycle while high.
REQ-012 oR, oG, oB  out  8 each  pixel colour.
REQ-013 oHS, oVS  out  1 each  horizontal and vertical sync, active-low.
REQ-014 oDE  out  1  data enable, high on active pixels.
REQ-015 oFrameStart  out  1  one-cycle pulse aligned with the first active pixel of each frame.
REQ-016 oUnderflow  out  1  sticky underflow flag.
REQ-017 oUnderflowCnt  out  16  count of underflowed pixels, saturating.

Function
REQ-018 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), and wrap to 0; v_cnt SHALL increment on each h_cnt wrap, count 0..V_TOTAL-1 (525), and wrap to 0.
REQ-019 Raw timing: active = h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hs_n low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752); vs_n low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) = [490,492).
REQ-020 FSM states: IDLE, WAIT_FILL, RUN.
- IDLE: counters held at 0.
- IDLE -> WAIT_FILL when enable=1.
- WAIT_FILL -> RUN when iEmpty=0 is sampled; counters start from (0,0) on the RUN entry cycle.
- RUN -> IDLE on the cycle after enable=0 is sampled, at any point in the frame.
REQ-021 oRead SHALL equal (state==RUN) AND raw active, combinationally from registered counters and state.
REQ-022 oDE, oHS, oVS and oFrameStart SHALL be the raw timing delayed by exactly RD_LATENCY registered stages, so the first oDE cycle coincides with the iData for the first oRead.
- oHS and oVS SHALL be 1 and oDE 0 in IDLE and WAIT_FILL, including pipeline contents.
REQ-023 raw frame-start = RUN and h_cnt==0 and v_cnt==0.
REQ-024 While delayed DE=1, oR/oG/oB SHALL register iData fields; while DE=0 they SHALL be 0.
REQ-025 Underflow: oRead=1 and iEmpty=1 in the same cycle marks that pixel. The mark is delayed RD_LATENCY stages; a marked pixel outputs R=G=B=0 and increments oUnderflowCnt. The counter saturates at 16'hFFFF. oUnderflow sets and stays set.
REQ-026 Underflow SHALL NOT stall or resynchronise timing; counters continue.
REQ-027 oUnderflow and oUnderflowCnt SHALL clear only on reset, not on enable toggling.

Reset
REQ-028 On reset_n=0, asynchronously:
- state=IDLE, h_cnt=v_cnt=0, all pipeline stages cleared.
- oRead=0, oDE=0, oHS=1, oVS=1, oFrameStart=0, RGB=0, oUnderflow=0, oUnderflowCnt=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately. After deassertion the block re-enters via IDLE/WAIT_FILL.

Verification
REQ-030 enable=1, iEmpty=0 -> RUN. oRead high 640 cycles per line for 480 lines. First oDE 2 cycles after first oRead, with oFrameStart on that same cycle. oHS low 96 clocks. Line period 800. Frame period 420000 clocks.
REQ-031 iData=32'h00AABBCC on first read -> 2 cycles later oR=8'hAA, oG=8'hBB, oB=8'hCC with oDE=1.
REQ-032 enable=1 with iEmpty=1 for 50 cycles -> stays WAIT_FILL, oRead=0, oHS=oVS=1. iEmpty falls -> RUN on the next cycle.
REQ-033 iEmpty=1 for 3 read cycles mid-line -> 3 black pixels, oUnderflowCnt=3, oUnderflow=1. Sync timing unchanged.
REQ-034 enable dropped at v_cnt=100 -> IDLE next cycle, oRead=0. Re-enable -> new frame from (0,0) after WAIT_FILL.
REQ-035 reset_n pulsed low mid-line -> all outputs at reset values asynchronously, oUnderflowCnt=0.

Source files
------------

// File: rtl/dvi_frame_reader.sv
// DVI timing generator that streams pixels from a frame-buffer read port.
// Sync/DE are delayed to line up with read data; underflowed pixels are blanked and counted.
module dvi_frame_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RD_LATENCY = 2
) (
  input  logic        dvi_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] iData,
  input  logic        iEmpty,
  output logic        oRead,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic        oHS,
  output logic        oVS,
  output logic        oDE,
  output logic        oFrameStart,
  output logic        oUnderflow,
  output logic [15:0] oUnderflowCnt
);

  // state     | meaning
  // IDLE      | output off, counters held at (0,0)
  // WAIT_FILL | enabled, waiting for the frame buffer to hold data
  // RUN       | timing counters running, pixels read every active cycle

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FILL, RUN} state_t;

  typedef struct packed {
    logic ufl;
    logic fs;
    logic vs_n;
    logic hs_n;
    logic de;
  } tstage_t;

  localparam tstage_t PIPE_IDLE = 5'b00110;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  tstage_t         raw;
  tstage_t         pre;
  tstage_t         pipe_q [RD_LATENCY];
  tstage_t         pipe_d [RD_LATENCY];
  logic [23:0]     rgb_q, rgb_d;
  logic            ufl_q, ufl_d;
  logic [15:0]     ucnt_q, ucnt_d;
  logic            run;
  logic            active_raw;
  logic            flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (enable) state_d = WAIT_FILL;
      WAIT_FILL: if (!enable) state_d = IDLE;
                 else if (!iEmpty) state_d = RUN;
      RUN:       if (!enable) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Counters only advance while staying in RUN, so every RUN entry starts at (0,0).
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (state_q == RUN && state_d == RUN) begin
      if (h_q == H_LAST_C) begin
        h_d = '0;
        v_d = (v_q == V_LAST_C) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
  end

  always_comb begin
    run        = (state_q == RUN);
    active_raw = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    oRead      = run && active_raw;
    raw.de     = oRead;
    raw.hs_n   = !(run && h_q >= HS_BEG_C && h_q < HS_END_C);
    raw.vs_n   = !(run && v_q >= VS_BEG_C && v_q < VS_END_C);
    raw.fs     = run && (h_q == '0) && (v_q == '0);
    raw.ufl    = oRead && iEmpty;
  end

  // Flushing on the same edge that leaves RUN keeps stale sync/DE out of IDLE.
  always_comb begin
    flush     = (state_d != RUN);
    pipe_d[0] = raw;
    for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    if (flush) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_d[i] = PIPE_IDLE;
    end
    pre = pipe_d[RD_LATENCY-1];
  end

  // iData is captured on the edge that raises oDE, so colour and DE appear together.
  always_comb begin
    rgb_d  = (pre.de && !pre.ufl) ? iData[23:0] : 24'h0;
    ufl_d  = ufl_q | (pre.de & pre.ufl);
    ucnt_d = ucnt_q;
    if (pre.de && pre.ufl && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge dvi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= PIPE_IDLE;
      rgb_q   <= 24'h0;
      ufl_q   <= 1'b0;
      ucnt_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= pipe_d[i];
      rgb_q   <= rgb_d;
      ufl_q   <= ufl_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign oDE           = pipe_q[RD_LATENCY-1].de;
  assign oHS           = pipe_q[RD_LATENCY-1].hs_n;
  assign oVS           = pipe_q[RD_LATENCY-1].vs_n;
  assign oFrameStart   = pipe_q[RD_LATENCY-1].fs;
  assign oR            = rgb_q[23:16];
  assign oG            = rgb_q[15:8];
  assign oB            = rgb_q[7:0];
  assign oUnderflow    = ufl_q;
  assign oUnderflowCnt = ucnt_q;

endmodule

// File: tb/tb_dvi_frame_reader.sv
// Directed bench for dvi_frame_reader on a shrunken 15x8 raster (8x4 active).
// k counts clocks from the first RUN cycle; all expectations below are hand-derived from it.
module tb_dvi_frame_reader;

  logic        dvi_clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] iData;
  logic        iEmpty;
  logic        oRead;
  logic [7:0]  oR, oG, oB;
  logic        oHS, oVS, oDE, oFrameStart, oUnderflow;
  logic [15:0] oUnderflowCnt;

  int checks = 0;
  int errors = 0;
  int k      = 0;
  int pix    = 0;

  logic       rd_a [130];
  logic       de_a [130];
  logic       hs_a [130];
  logic       vs_a [130];
  logic       fs_a [130];
  logic [7:0] r_a  [130];
  logic [7:0] g_a  [130];
  logic [7:0] b_a  [130];

  dvi_frame_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .RD_LATENCY(2)
  ) dut (
    .dvi_clk(dvi_clk), .reset_n(reset_n), .enable(enable),
    .iData(iData), .iEmpty(iEmpty), .oRead(oRead),
    .oR(oR), .oG(oG), .oB(oB), .oHS(oHS), .oVS(oVS), .oDE(oDE),
    .oFrameStart(oFrameStart), .oUnderflow(oUnderflow),
    .oUnderflowCnt(oUnderflowCnt)
  );

  always #5 dvi_clk = ~dvi_clk;

  // Frame buffer: a read in cycle t presents its word during cycle t+1.
  initial begin
    logic rd_s;
    logic [7:0] p;
    iData = 32'h0;
    forever begin
      @(negedge dvi_clk);
      rd_s = oRead;
      @(posedge dvi_clk);
      #1;
      if (rd_s) begin
        p     = pix[7:0];
        iData = {8'h5A, 8'hAA ^ p, 8'hBB, 8'hCC + p};
        pix++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge dvi_clk);
    #1;
    k++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    iEmpty  = 1'b1;
    repeat (3) step();
    checks++; if (oRead !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", oRead); end
    checks++; if (oDE !== 1'b0) begin errors++; $display("FAIL reset_de got %b want 0", oDE); end
    checks++; if ({oHS, oVS} !== 2'b11) begin errors++; $display("FAIL reset_sync got %b want 11", {oHS, oVS}); end
    checks++; if (oFrameStart !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", oFrameStart); end
    checks++; if ({oR, oG, oB} !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 0", {oR, oG, oB}); end
    checks++; if ({oUnderflow, oUnderflowCnt} !== 17'h0) begin errors++; $display("FAIL reset_ufl got %b/%0d want 0/0", oUnderflow, oUnderflowCnt); end
    reset_n = 1'b1;
  endtask

  task automatic test_wait_fill();
    step();
    enable = 1'b1;
    iEmpty = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if ({oRead, oHS, oVS, oDE} !== 4'b0110) begin
        errors++; $display("FAIL wait_fill cycle %0d got rd/hs/vs/de %b want 0110", i, {oRead, oHS, oVS, oDE});
      end
    end
    pix    = 0;
    iEmpty = 1'b0;
    step();
    k = 0;
    checks++; if (oRead !== 1'b1) begin errors++; $display("FAIL run_entry_read got %b want 1", oRead); end
  endtask

  task automatic test_timing();
    int s_rd, s_de, s_hs, s_vs, s_fs;
    for (int i = 0; i < 130; i++) begin
      rd_a[i] = oRead; de_a[i] = oDE; hs_a[i] = oHS; vs_a[i] = oVS;
      fs_a[i] = oFrameStart; r_a[i] = oR; g_a[i] = oG; b_a[i] = oB;
      step();
    end
    s_rd = 0; s_de = 0; s_hs = 0; s_vs = 0; s_fs = 0;
    for (int i = 0; i < 120; i++) begin
      s_rd += int'(rd_a[i]);
      s_de += int'(de_a[i+2]);
      s_hs += int'(!hs_a[i+2]);
      s_vs += int'(!vs_a[i+2]);
    end
    for (int i = 0; i < 130; i++) s_fs += int'(fs_a[i]);
    checks++; if (s_rd !== 32) begin errors++; $display("FAIL read_count got %0d want 32", s_rd); end
    checks++; if (rd_a[7] !== 1'b1 || rd_a[8] !== 1'b0) begin errors++; $display("FAIL read_edge got %b%b want 10", rd_a[7], rd_a[8]); end
    checks++; if (s_de !== 32) begin errors++; $display("FAIL de_count got %0d want 32", s_de); end
    checks++; if (de_a[1] !== 1'b0 || de_a[2] !== 1'b1) begin errors++; $display("FAIL de_latency got %b%b want 01", de_a[1], de_a[2]); end
    checks++; if (fs_a[2] !== 1'b1) begin errors++; $display("FAIL fs_first got %b want 1", fs_a[2]); end
    checks++; if (s_fs !== 2 || fs_a[122] !== 1'b1) begin errors++; $display("FAIL fs_period got cnt=%0d fs122=%b want 2/1", s_fs, fs_a[122]); end
    checks++; if ({r_a[2], g_a[2], b_a[2]} !== 24'hAABBCC) begin errors++; $display("FAIL pix0_rgb got %h want aabbcc", {r_a[2], g_a[2], b_a[2]}); end
    checks++; if ({r_a[3], g_a[3], b_a[3]} !== 24'hABBBCD) begin errors++; $display("FAIL pix1_rgb got %h want abbbcd", {r_a[3], g_a[3], b_a[3]}); end
    checks++; if (de_a[10] !== 1'b0 || r_a[10] !== 8'h0) begin errors++; $display("FAIL blank_rgb got de=%b r=%h want 0/00", de_a[10], r_a[10]); end
    checks++; if ({hs_a[11], hs_a[12], hs_a[14], hs_a[15]} !== 4'b1001) begin errors++; $display("FAIL hs_window got %b want 1001", {hs_a[11], hs_a[12], hs_a[14], hs_a[15]}); end
    checks++; if (hs_a[27] !== 1'b0 || hs_a[26] !== 1'b1) begin errors++; $display("FAIL hs_period got %b%b want 10", hs_a[26], hs_a[27]); end
    checks++; if (s_hs !== 24) begin errors++; $display("FAIL hs_count got %0d want 24", s_hs); end
    checks++; if (vs_a[76] !== 1'b1 || vs_a[77] !== 1'b0) begin errors++; $display("FAIL vs_start got %b%b want 10", vs_a[76], vs_a[77]); end
    checks++; if (s_vs !== 30) begin errors++; $display("FAIL vs_count got %0d want 30", s_vs); end
  endtask

  task automatic test_underflow();
    while (k < 150) begin
      iEmpty = (k >= 137 && k <= 139);
      if (k == 137) begin
        checks++; if (oRead !== 1'b1) begin errors++; $display("FAIL ufl_read got %b want 1", oRead); end
      end
      if (k == 138) begin
        checks++; if (oUnderflow !== 1'b0) begin errors++; $display("FAIL ufl_early got %b want 0", oUnderflow); end
      end
      if (k >= 139 && k <= 141) begin
        checks++;
        if ({oDE, oR, oG, oB} !== 25'h1000000) begin
          errors++; $display("FAIL ufl_black k=%0d got de=%b rgb=%h want 1/000000", k, oDE, {oR, oG, oB});
        end
      end
      if (k == 142) begin
        checks++; if ({oR, oG, oB} !== 24'h87BBF9) begin errors++; $display("FAIL ufl_resume got %h want 87bbf9", {oR, oG, oB}); end
        checks++; if (oUnderflowCnt !== 16'd3 || oUnderflow !== 1'b1) begin errors++; $display("FAIL ufl_count got %0d/%b want 3/1", oUnderflowCnt, oUnderflow); end
      end
      if (k == 146 || k == 147) begin
        checks++; if (oHS !== (k == 146)) begin errors++; $display("FAIL ufl_hs k=%0d got %b want %b", k, oHS, k == 146); end
      end
      step();
    end
    iEmpty = 1'b0;
  endtask

  task automatic test_disable();
    while (k < 167) begin
      if (k == 152) begin
        checks++; if (oRead !== 1'b1) begin errors++; $display("FAIL dis_pre_read got %b want 1", oRead); end
        enable = 1'b0;
      end
      if (k == 153) begin
        checks++;
        if ({oRead, oDE, oHS, oVS, oR} !== 12'b0011_0000_0000) begin
          errors++; $display("FAIL dis_idle got rd/de/hs/vs=%b r=%h want 0011/00", {oRead, oDE, oHS, oVS}, oR);
        end
      end
      if (k == 160) begin
        checks++; if (oUnderflowCnt !== 16'd3 || oUnderflow !== 1'b1) begin errors++; $display("FAIL dis_keep_ufl got %0d/%b want 3/1", oUnderflowCnt, oUnderflow); end
        enable = 1'b1;
      end
      if (k == 161 || k == 162) begin
        checks++; if (oRead !== (k == 162)) begin errors++; $display("FAIL reen_read k=%0d got %b want %b", k, oRead, k == 162); end
      end
      if (k == 164) begin
        checks++; if (oFrameStart !== 1'b1) begin errors++; $display("FAIL reen_fs got %b want 1", oFrameStart); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    checks++; if (oDE !== 1'b1) begin errors++; $display("FAIL rst_pre_de got %b want 1", oDE); end
    reset_n = 1'b0;
    #2;
    checks++;
    if ({oRead, oDE, oHS, oVS, oFrameStart} !== 5'b00110) begin
      errors++; $display("FAIL rst_async_ctl got %b want 00110", {oRead, oDE, oHS, oVS, oFrameStart});
    end
    checks++;
    if ({oR, oG, oB, oUnderflow, oUnderflowCnt} !== 41'h0) begin
      errors++; $display("FAIL rst_async_data got rgb=%h ufl=%b cnt=%0d want 0", {oR, oG, oB}, oUnderflow, oUnderflowCnt);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++; if (oRead !== 1'b0) begin errors++; $display("FAIL rst_wait_read got %b want 0", oRead); end
    step();
    checks++; if (oRead !== 1'b1) begin errors++; $display("FAIL rst_run_read got %b want 1", oRead); end
  endtask

  initial begin
    test_reset();
    test_wait_fill();
    test_timing();
    test_underflow();
    test_disable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
